// File: rtl/spu32_alu_pkg.sv
// spu32_alu_pkg: shared ALU widths and opcode encodings for the SPU32 core.
package spu32_alu_pkg;
    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLT  = 4'd5;
    localparam logic [3:0] ALUOP_SLTU = 4'd6;
    localparam logic [3:0] ALUOP_SLL  = 4'd7;
    localparam logic [3:0] ALUOP_SRL  = 4'd8;
    localparam logic [3:0] ALUOP_SRA  = 4'd9;
endpackage

// File: rtl/spu32_cpu_alu_shifter.sv
// spu32_cpu_alu_shifter: shift unit; iterative one bit per cycle, or a one-cycle
// barrel shifter when SPU32_ALU_BARREL_SHIFTER_EN is defined.
module spu32_cpu_alu_shifter
    import spu32_alu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic [XLEN-1:0]    data_o
);
    logic [XLEN-1:0] data_q, data_d;
    assign data_o = data_q;
`ifdef SPU32_ALU_BARREL_SHIFTER_EN
    assign busy_o = 1'b0;
    always_comb begin
        data_d = data_q;
        if (start_i)
            data_d = (op_i == ALUOP_SLL) ? data_i << shamt_i
                   : (op_i == ALUOP_SRA) ? XLEN'($signed(data_i) >>> shamt_i)
                   : data_i >> shamt_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i)
            data_q <= '0;
        else if (en_i)
            data_q <= data_d;
    end
`else
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               busy_q, busy_d;
    logic [3:0]         op_q, op_d;
    logic [XLEN-1:0]    step;
    assign busy_o = busy_q;
    // the direction is latched at start because the opcode input is ignored while busy
    assign step = (op_q == ALUOP_SLL) ? {data_q[XLEN-2:0], 1'b0}
                                      : {(op_q == ALUOP_SRA) & data_q[XLEN-1], data_q[XLEN-1:1]};
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        busy_d  = busy_q;
        op_d    = op_q;
        if (start_i) begin
            data_d  = data_i;
            count_d = shamt_i;
            busy_d  = shamt_i != '0;
            op_d    = op_i;
        end else if (busy_q) begin
            data_d  = step;
            count_d = count_q - 1'b1;
            busy_d  = count_q != SHAMT_W'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            op_q    <= '0;
        end else if (en_i) begin
            data_q  <= data_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            op_q    <= op_d;
        end
    end
`endif
endmodule

// File: rtl/spu32_cpu_alu.sv
// spu32_cpu_alu: RV32I ALU with registered result and branch compare flags.
// Define SPU32_ALU_BARREL_SHIFTER_EN for single-cycle shifts.
module spu32_cpu_alu
    import spu32_alu_pkg::*;
(
    input  logic            I_clk,
    input  logic            I_reset,
    input  logic            I_en,
    input  logic [XLEN-1:0] I_dataS1,
    input  logic [XLEN-1:0] I_dataS2,
    input  logic [3:0]      I_aluop,
    output logic            O_busy,
    output logic [XLEN-1:0] O_data,
    output logic            O_lt,
    output logic            O_ltu,
    output logic            O_eq
);
    logic            is_shift, sel_q, lt_q, ltu_q, eq_q, lt_d, ltu_d, sh_busy;
    logic [XLEN-1:0] res_q, res_d, sh_data;
    assign is_shift = I_aluop inside {ALUOP_SLL, ALUOP_SRL, ALUOP_SRA};
    assign lt_d     = $signed(I_dataS1) < $signed(I_dataS2);
    assign ltu_d    = I_dataS1 < I_dataS2;
    spu32_cpu_alu_shifter u_shifter (
        .clk_i   (I_clk),
        .rst_i   (I_reset),
        .en_i    (I_en),
        .start_i (is_shift && !sh_busy),
        .op_i    (I_aluop),
        .data_i  (I_dataS1),
        .shamt_i (I_dataS2[SHAMT_W-1:0]),
        .busy_o  (sh_busy),
        .data_o  (sh_data)
    );
    always_comb begin
        res_d = I_dataS1;
        case (I_aluop)
            ALUOP_ADD:  res_d = I_dataS1 + I_dataS2;
            ALUOP_SUB:  res_d = I_dataS1 - I_dataS2;
            ALUOP_AND:  res_d = I_dataS1 & I_dataS2;
            ALUOP_OR:   res_d = I_dataS1 | I_dataS2;
            ALUOP_XOR:  res_d = I_dataS1 ^ I_dataS2;
            ALUOP_SLT:  res_d = {{(XLEN-1){1'b0}}, lt_d};
            ALUOP_SLTU: res_d = {{(XLEN-1){1'b0}}, ltu_d};
            default:    res_d = I_dataS1;
        endcase
    end
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            res_q <= '0;
            sel_q <= 1'b0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
            eq_q  <= 1'b0;
        end else if (I_en && !sh_busy) begin
            res_q <= res_d;
            sel_q <= is_shift;
            lt_q  <= lt_d;
            ltu_q <= ltu_d;
            eq_q  <= I_dataS1 == I_dataS2;
        end
    end
    assign O_data = sel_q ? sh_data : res_q;
    assign O_busy = sh_busy;
    assign O_lt   = lt_q;
    assign O_ltu  = ltu_q;
    assign O_eq   = eq_q;
endmodule

// File: tb/tb_spu32_cpu_alu.sv
// tb_spu32_cpu_alu: directed vectors with hand-computed results for spu32_cpu_alu.
module tb_spu32_cpu_alu;
    import spu32_alu_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, busy, lt, ltu, eq;
    logic [31:0] s1 = '0, s2 = '0, dout;
    logic [3:0]  aluop = ALUOP_ADD;
    int          n_cmp = 0, n_bad = 0, edges;
    logic        seen;

    spu32_cpu_alu dut (
        .I_clk(clk), .I_reset(rst), .I_en(en), .I_dataS1(s1), .I_dataS2(s2),
        .I_aluop(aluop), .O_busy(busy), .O_data(dout), .O_lt(lt), .O_ltu(ltu), .O_eq(eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        aluop = op;
        s1 = a;
        s2 = b;
        tick();
    endtask

    // Issues a shift, then scrambles the inputs and waits (bounded) for busy to drop.
    task automatic run_shift(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int n, output logic rose);
        run_op(op, a, b);
        n = 1;
        rose = busy;
        aluop = ALUOP_ADD;
        s1 = '0;
        s2 = '0;
        while (busy && n < 64) begin
            tick();
            n++;
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data", dout, 32'h0);
        chk("rst_flags", {28'h0, busy, lt, ltu, eq}, 32'h0);
        rst = 1'b0;

        run_op(ALUOP_ADD, 32'd40, 32'd2);        chk("add1", dout, 32'd42);
        run_op(ALUOP_ADD, 32'd44, -32'sd2);      chk("add2", dout, 32'd42);
        run_op(ALUOP_SUB, 32'd8, -32'sd2);       chk("sub1", dout, 32'd10);
        run_op(ALUOP_SUB, -32'sd2, 32'd13);      chk("sub2", dout, 32'hFFFF_FFF1);
        chk("sub2_flags", {29'h0, lt, ltu, eq}, 32'b100);
        run_op(ALUOP_SUB, 32'd1337, 32'd337);    chk("sub3", dout, 32'd1000);

        run_op(ALUOP_ADD, 32'd1337, 32'd1337);   chk("flags_eq", {29'h0, lt, ltu, eq}, 32'b001);
        run_op(ALUOP_ADD, -32'sd5, 32'd5);       chk("flags_lt", {29'h0, lt, ltu, eq}, 32'b100);
        run_op(ALUOP_ADD, 32'd5, -32'sd5);       chk("flags_ltu", {29'h0, lt, ltu, eq}, 32'b010);
        run_op(ALUOP_SLT, -32'sd5, 32'd5);       chk("slt", dout, 32'd1);
        run_op(ALUOP_SLTU, -32'sd5, 32'd5);      chk("sltu", dout, 32'd0);

        run_op(ALUOP_XOR, 32'hFF, 32'hFFF);      chk("xor", dout, 32'hF00);
        run_op(ALUOP_OR, 32'hFF, 32'hFFF);       chk("or", dout, 32'hFFF);
        run_op(ALUOP_AND, 32'hFF, 32'hFFF);      chk("and", dout, 32'hFF);
        run_op(4'd12, 32'hDEAD_BEEF, 32'h1);     chk("move", dout, 32'hDEAD_BEEF);

`ifdef SPU32_ALU_BARREL_SHIFTER_EN
        run_shift(ALUOP_SLL, 32'd1, 32'd3, edges, seen);
        chk("sll_data", dout, 32'd8);
        chk("sll_edges", edges, 32'd1);
        run_shift(ALUOP_SRL, 32'hFFFF_FFFF, 32'd8, edges, seen);
        chk("srl_data", dout, 32'h00FF_FFFF);
        run_shift(ALUOP_SRA, 32'h8000_0000, 32'd3, edges, seen);
        chk("sra_data", dout, 32'hF000_0000);
`else
        run_shift(ALUOP_SLL, 32'd1, 32'd3, edges, seen);
        chk("sll_busy", {31'h0, seen}, 32'd1);
        chk("sll_edges", edges, 32'd4);
        chk("sll_data", dout, 32'd8);
        run_shift(ALUOP_SRL, 32'hFFFF_FFFF, 32'd8, edges, seen);
        chk("srl_edges", edges, 32'd9);
        chk("srl_data", dout, 32'h00FF_FFFF);
        chk("srl_flags_held", {29'h0, lt, ltu, eq}, 32'b100);
        run_shift(ALUOP_SRA, 32'h8000_0000, 32'd3, edges, seen);
        chk("sra_edges", edges, 32'd4);
        chk("sra_data", dout, 32'hF000_0000);
`endif
        run_shift(ALUOP_SLL, 32'h1234, 32'd0, edges, seen);
        chk("sh0_busy", {31'h0, seen}, 32'd0);
        chk("sh0_edges", edges, 32'd1);
        chk("sh0_data", dout, 32'h1234);
        run_op(ALUOP_ADD, 32'd3, 32'd4);
        chk("after_shift", dout, 32'd7);

`ifndef SPU32_ALU_BARREL_SHIFTER_EN
        run_op(ALUOP_SLL, 32'd1, 32'd4);
        aluop = ALUOP_ADD;
        tick();
        chk("stall_pre", dout, 32'd2);
        en = 1'b0;
        repeat (3) tick();
        chk("stall_data", dout, 32'd2);
        chk("stall_busy", {31'h0, busy}, 32'd1);
        en = 1'b1;
        edges = 0;
        while (busy && edges < 64) begin
            tick();
            edges++;
        end
        chk("stall_rest", edges, 32'd3);
        chk("stall_data_end", dout, 32'd16);

        run_op(ALUOP_SLL, 32'd1, 32'd20);
        repeat (4) tick();
        chk("mid_busy", {31'h0, busy}, 32'd1);
        chk("mid_data", dout, 32'd16);
        rst = 1'b1;
        tick();
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_data", dout, 32'd0);
        rst = 1'b0;
`endif

        run_op(ALUOP_ADD, 32'd1, 32'd1);
        chk("en_pre", dout, 32'd2);
        en = 1'b0;
        run_op(ALUOP_SUB, 32'd10, 32'd3);
        chk("en_hold", dout, 32'd2);
        chk("en_hold_flags", {29'h0, lt, ltu, eq}, 32'b001);
        en = 1'b1;
        tick();
        chk("en_resume", dout, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
